// File: rtl/aes_round_engine_pkg.sv
// Shared AES definitions: FSM encoding, mode constants, GF(2^8) arithmetic
// and the forward/inverse on-the-fly key-schedule helpers.
package aes_defs;
  localparam int   BLK_W    = 128;
  localparam int   NR_DEF   = 10;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYGEN = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Byte i of a block, byte 0 in the most significant position (column-major state).
  function automatic logic [7:0] blk_byte(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254, which maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [3:0] i);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]) ^ rcon(i), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot(rk[31:0], i);
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Recovers round key i-1 from round key i.
  function automatic logic [127:0] expand_key_inv(input logic [127:0] rk, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot(w3, i);
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_round_engine_round_step.sv
// AES byte transforms and the combinational single-round step (forward or inverse,
// with or without (Inv)MixColumns) built from them.
module subBytes128 import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);
  always_comb
    for (int i = 0; i < 16; i++) dout[8*i +: 8] = sbox(din[8*i +: 8]);
endmodule

module subBytes128_inv import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);
  always_comb
    for (int i = 0; i < 16; i++) dout[8*i +: 8] = inv_sbox(din[8*i +: 8]);
endmodule

module shift128 import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dout[127-8*(4*c+r) -: 8] = blk_byte(din, 4*((c+r)%4) + r);
  end
endmodule

module shift128_inv import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dout[127-8*(4*c+r) -: 8] = blk_byte(din, 4*((c+4-r)%4) + r);
  end
endmodule

module mixCol128 import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dout[127-8*(4*c+r) -: 8] = gmul(8'h02, blk_byte(din, 4*c + r))
                                 ^ gmul(8'h03, blk_byte(din, 4*c + (r+1)%4))
                                 ^ blk_byte(din, 4*c + (r+2)%4)
                                 ^ blk_byte(din, 4*c + (r+3)%4);
  end
endmodule

module mixCol128_inv import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dout[127-8*(4*c+r) -: 8] = gmul(8'h0e, blk_byte(din, 4*c + r))
                                 ^ gmul(8'h0b, blk_byte(din, 4*c + (r+1)%4))
                                 ^ gmul(8'h0d, blk_byte(din, 4*c + (r+2)%4))
                                 ^ gmul(8'h09, blk_byte(din, 4*c + (r+3)%4));
  end
endmodule

module addRoundKey import aes_defs::*; (
  input  logic [BLK_W-1:0] din,
  input  logic [BLK_W-1:0] rk,
  output logic [BLK_W-1:0] dout
);
  assign dout = din ^ rk;
endmodule

module aes_round_step import aes_defs::*; (
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] round_key,
  input  logic             mode,
  input  logic             final_flag,
  output logic [BLK_W-1:0] result
);
  logic [BLK_W-1:0] sb, sr, mc, enc_pre, enc_res;
  logic [BLK_W-1:0] isr, isb, dak, imc, dec_res;

  subBytes128 u_sb  (.din(state), .dout(sb));
  shift128    u_sr  (.din(sb),    .dout(sr));
  mixCol128   u_mc  (.din(sr),    .dout(mc));
  assign enc_pre = final_flag ? sr : mc;
  addRoundKey u_ake (.din(enc_pre), .rk(round_key), .dout(enc_res));

  // Inverse round adds the key before InvMixColumns (equivalent-free FIPS order).
  shift128_inv    u_isr (.din(state), .dout(isr));
  subBytes128_inv u_isb (.din(isr),   .dout(isb));
  addRoundKey     u_akd (.din(isb),   .rk(round_key), .dout(dak));
  mixCol128_inv   u_imc (.din(dak),   .dout(imc));
  assign dec_res = final_flag ? dak : imc;

  assign result = (mode == MODE_DEC) ? dec_res : enc_res;
endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encrypt/decrypt core: one round per clock, on-the-fly key
// schedule in both directions and a cached last-round key for decryption.
module aes_round_engine import aes_defs::*; #(
  parameter int NR        = NR_DEF,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [BLK_W-1:0] din,
  input  logic [BLK_W-1:0] key,
  output logic             busy,
  output logic [BLK_W-1:0] dout,
  output logic             dout_valid
);
  localparam logic [3:0] NR_C = 4'(NR);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q;
  logic             mode_q, cache_ok;
  logic [BLK_W-1:0] st_q, rk_q, din_q, key_q, last_rk, cached_key;
  logic [BLK_W-1:0] rk_fwd, rk_inv, round_key, round_out;
  logic             accept, cache_hit, final_flag, round_exit;

  assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign cache_hit  = KEY_CACHE && cache_ok && (key == cached_key);
  assign rk_fwd     = expand_key(rk_q, cnt_q);
  assign rk_inv     = expand_key_inv(rk_q, cnt_q);
  assign round_key  = (mode_q == MODE_DEC) ? rk_inv : rk_fwd;
  assign final_flag = (state_q == ST_FINAL);
  assign round_exit = (mode_q == MODE_DEC) ? (cnt_q == 4'd2) : (cnt_q == NR_C - 4'd1);

  aes_round_step u_step (
    .state     (st_q),
    .round_key (round_key),
    .mode      (mode_q),
    .final_flag(final_flag),
    .result    (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!accept)                               state_d = ST_IDLE;
        else if (mode == MODE_DEC && !cache_hit)   state_d = ST_KEYGEN;
        else                                       state_d = ST_INIT;
      end
      ST_KEYGEN: if (cnt_q == NR_C) state_d = ST_INIT;
      ST_INIT:   state_d = (NR == 1) ? ST_FINAL : ST_ROUND;
      ST_ROUND:  if (round_exit) state_d = ST_FINAL;
      ST_FINAL:  state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = !(state_q == ST_IDLE || state_q == ST_DONE);
    dout_valid = (state_q == ST_DONE);
  end

  // Control, cache and result registers: cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      mode_q     <= MODE_ENC;
      cache_ok   <= 1'b0;
      cached_key <= '0;
      last_rk    <= '0;
      dout       <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (accept) begin
          mode_q <= mode;
          cnt_q  <= 4'd1;
        end
        ST_KEYGEN: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == NR_C) begin
            last_rk    <= rk_fwd;
            cached_key <= key_q;
            cache_ok   <= 1'b1;
          end
        end
        ST_INIT:  cnt_q <= (mode_q == MODE_DEC) ? NR_C : 4'd1;
        ST_ROUND: cnt_q <= (mode_q == MODE_DEC) ? cnt_q - 4'd1 : cnt_q + 4'd1;
        ST_FINAL: dout  <= round_out;
        default: ;
      endcase
    end
  end

  // Datapath registers: always written before being read, so left unreset.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE, ST_DONE: if (accept) begin
        din_q <= din;
        key_q <= key;
        rk_q  <= key;
      end
      ST_KEYGEN: rk_q <= rk_fwd;
      ST_INIT: begin
        st_q <= din_q ^ ((mode_q == MODE_DEC) ? last_rk : key_q);
        rk_q <= (mode_q == MODE_DEC) ? last_rk : key_q;
      end
      ST_ROUND: begin
        st_q <= round_out;
        rk_q <= round_key;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: FIPS-197 vectors plus randomized blocks against a
// table-driven AES reference, cache/latency, back-to-back, reset and NR=1 checks.
module tb_aes_round_engine;
  localparam int NR_T   = 10;
  localparam int L_FAST = NR_T + 1;
  localparam int L_MISS = 2 * NR_T + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, mode, start1, mode1;
  logic [127:0] din, key, din1, key1;
  logic         busy, dout_valid, busy1, dout_valid1;
  logic [127:0] dout, dout1;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic         c_ok;
  logic [127:0] c_key;

  aes_round_engine #(.NR(NR_T), .KEY_CACHE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .din(din), .key(key),
    .busy(busy), .dout(dout), .dout_valid(dout_valid)
  );

  aes_round_engine #(.NR(1), .KEY_CACHE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .din(din1), .key(key1),
    .busy(busy1), .dout(dout1), .dout_valid(dout_valid1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [7:0] bget(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Full forward key schedule up to round r, returning round key r.
  function automatic logic [127:0] m_rk(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*r + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]] ^ rc, sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_sub(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = inv ? isbox[x[8*i +: 8]] : sbox[x[8*i +: 8]];
    return y;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = inv ? bget(x, 4*((c+4-r)%4) + r) : bget(x, 4*((c+r)%4) + r);
    return y;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    for (int c = 0; c < 4; c++) begin
      a0 = bget(x, 4*c); a1 = bget(x, 4*c+1); a2 = bget(x, 4*c+2); a3 = bget(x, 4*c+3);
      if (!inv) begin
        b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end else begin
        b0 = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
        b1 = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
        b2 = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
        b3 = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
      end
      y[127-32*c -: 32] = {b0, b1, b2, b3};
    end
    return y;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] k, input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ m_rk(k, 0);
    for (int r = 1; r <= nr; r++) begin
      s = m_shift(m_sub(s, 1'b0), 1'b0);
      if (r < nr) s = m_mix(s, 1'b0);
      s = s ^ m_rk(k, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] m_dec(input logic [127:0] k, input logic [127:0] ct, input int nr);
    logic [127:0] s;
    s = ct ^ m_rk(k, nr);
    for (int r = nr - 1; r >= 0; r--) begin
      s = m_sub(m_shift(s, 1'b1), 1'b1) ^ m_rk(k, r);
      if (r > 0) s = m_mix(s, 1'b1);
    end
    return s;
  endfunction

  function automatic int exp_lat(input logic m, input logic [127:0] k);
    if (m && !(c_ok && k == c_key)) return L_MISS;
    return L_FAST;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on dut (sel=0) or dut1 (sel=1): latency, result, busy and pulse width.
  task automatic run_op(input int sel, input logic m, input logic [127:0] d, input logic [127:0] k,
                        input int lat, input logic [127:0] exp_out, input string tag);
    int   edges;
    logic got;
    @(negedge clk);
    if (sel == 0) begin start = 1'b1; mode = m; din = d; key = k; end
    else          begin start1 = 1'b1; mode1 = m; din1 = d; key1 = k; end
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
    chk({tag, " busy"}, 128'((sel == 0) ? busy : busy1), 128'd1);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      got = (sel == 0) ? dout_valid : dout_valid1;
    end
    chk({tag, " latency"}, 128'(edges), 128'(lat));
    chk({tag, " dout"}, (sel == 0) ? dout : dout1, exp_out);
    @(posedge clk); #1;
    chk({tag, " pulse"}, 128'((sel == 0) ? dout_valid : dout_valid1), 128'd0);
    if (sel == 0 && m) begin c_ok = 1'b1; c_key = k; end
  endtask

  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FRK = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    logic [127:0] k, d, e, k2, dd;
    logic         m, prev_v;
    logic [127:0] bb_din [4];
    logic [127:0] bb_exp [4];
    logic         bb_mode [4];
    int           idx, cyc, last_t, extra;

    build_sbox();
    c_ok = 1'b0; c_key = '0;
    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; din = '0; key = '0;
    start1 = 1'b0; mode1 = 1'b0; din1 = '0; key1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 128'(busy), 128'd0);
    chk("rst dout_valid", 128'(dout_valid), 128'd0);
    chk("rst dout", dout, 128'd0);
    chk("rst cache_ok", 128'(dut.cache_ok), 128'd0);
    chk("rst cnt", 128'(dut.cnt_q), 128'd0);
    chk("rst last_rk", dut.last_rk, 128'd0);
    chk("rst busy1", 128'(busy1), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // FIPS-197 C.1 vectors
    run_op(0, 1'b0, FPT, FK, L_FAST, FCT, "fips enc");
    run_op(0, 1'b1, FCT, FK, L_MISS, FPT, "fips dec cold");
    chk("fips last_rk", dut.last_rk, FRK);
    chk("cache_ok set", 128'(dut.cache_ok), 128'd1);
    run_op(0, 1'b1, FCT, FK, L_FAST, FPT, "fips dec hit");
    d = rnd128();
    run_op(0, 1'b1, d, '0, L_MISS, m_dec('0, d, NR_T), "zero key dec");
    chk("zero key last_rk", dut.last_rk, m_rk('0, NR_T));

    // Randomized blocks; every other op reuses the cached key
    for (int i = 0; i < 6; i++) begin
      m = 1'($urandom_range(0, 1));
      k = (i % 2 == 1 && c_ok) ? c_key : rnd128();
      d = rnd128();
      e = m ? m_dec(k, d, NR_T) : m_enc(k, d, NR_T);
      run_op(0, m, d, k, exp_lat(m, k), e, $sformatf("rand%0d %s", i, m ? "dec" : "enc"));
    end

    // Encryption under another key leaves the cache intact
    k  = c_key;
    k2 = rnd128();
    d  = rnd128();
    run_op(0, 1'b0, d, k2, L_FAST, m_enc(k2, d, NR_T), "enc other key");
    run_op(0, 1'b1, d, k, L_FAST, m_dec(k, d, NR_T), "dec after enc hit");

    // start held high, alternating enc/dec, garbage inputs while busy
    for (int j = 0; j < 4; j++) begin
      bb_din[j]  = rnd128();
      bb_mode[j] = 1'(j % 2);
      bb_exp[j]  = bb_mode[j] ? m_dec(c_key, bb_din[j], NR_T) : m_enc(c_key, bb_din[j], NR_T);
    end
    @(negedge clk);
    start = 1'b1; mode = bb_mode[0]; din = bb_din[0]; key = c_key;
    idx = 0; cyc = 0; last_t = 0; prev_v = 1'b0;
    while (idx < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (dout_valid) begin
        chk($sformatf("b2b%0d dout", idx), dout, bb_exp[idx]);
        chk($sformatf("b2b%0d pulse", idx), 128'(prev_v), 128'd0);
        if (idx > 0) chk($sformatf("b2b%0d period", idx), 128'(cyc - last_t), 128'(NR_T + 2));
        last_t = cyc;
        idx++;
        if (idx < 4) begin mode = bb_mode[idx]; din = bb_din[idx]; key = c_key; end
        else start = 1'b0;
      end else begin
        mode = 1'($urandom_range(0, 1)); din = rnd128(); key = rnd128();
      end
      prev_v = dout_valid;
    end
    chk("b2b results", 128'(idx), 128'd4);
    extra = 0;
    repeat (2 * NR_T + 4) begin
      @(negedge clk);
      if (dout_valid) extra++;
    end
    chk("b2b no extra", 128'(extra), 128'd0);

    // Reset mid-decryption (cache miss, during KEYGEN)
    dd = c_key;
    k  = rnd128();
    @(negedge clk);
    start = 1'b1; mode = 1'b1; din = rnd128(); key = k;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 128'(busy), 128'd0);
    chk("midrst dout_valid", 128'(dout_valid), 128'd0);
    chk("midrst dout", dout, 128'd0);
    chk("midrst cache_ok", 128'(dut.cache_ok), 128'd0);
    c_ok = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    d = rnd128();
    run_op(0, 1'b1, d, dd, L_MISS, m_dec(dd, d, NR_T), "post-rst dec");
    run_op(0, 1'b1, d, dd, L_FAST, m_dec(dd, d, NR_T), "post-rst dec hit");

    // NR=1 instance
    k = rnd128();
    d = rnd128();
    e = m_enc(k, d, 1);
    run_op(1, 1'b0, d, k, 2, e, "nr1 enc");
    run_op(1, 1'b1, e, k, 3, d, "nr1 dec cold");
    run_op(1, 1'b1, e, k, 2, d, "nr1 dec hit");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
